point_step_sched: RTL and testbench



---
 rtl/point_pkg.sv | 24 ++
 rtl/point_step_alu.sv | 63 ++++++
 rtl/point_step_sched.sv | 133 +++++++++++++
 tb/tb_point_step_sched.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/point_pkg.sv
// Shared point types for the point step scheduler and its step ALU.
package point_pkg;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
  } t_point;

  typedef enum logic [1:0] {
    OP_INC  = 2'd0,
    OP_DEC  = 2'd1,
    OP_HOLD = 2'd2,
    OP_CLR  = 2'd3
  } t_point_op;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } t_sched_state;

  localparam t_point POINT_ZERO = '{x: 8'h00, y: 8'h00};

endpackage

// File: rtl/point_step_alu.sv
// Combinational per-field step of a t_point (inc/dec/hold/clear).
// POINT_STEP_SCHED_SATURATE_EN: INC/DEC clip at 8'hff/8'h00 and report o_sat.
module point_step_alu
  import point_pkg::*;
#(
  parameter logic [7:0] STEP = 8'd1
) (
  input  t_point    i_pnt,
  input  t_point_op i_op,
`ifdef POINT_STEP_SCHED_SATURATE_EN
  output logic      o_sat,
`endif
  output t_point    o_pnt
);

  // Fields never interact: each one wraps (or clips) on its own.
  function automatic logic [7:0] step_val(input logic [7:0] v, input t_point_op op);
    logic [7:0] r;
    r = v;
    case (op)
      OP_INC: begin
`ifdef POINT_STEP_SCHED_SATURATE_EN
        r = (v > (8'hff - STEP)) ? 8'hff : (v + STEP);
`else
        r = v + STEP;
`endif
      end
      OP_DEC: begin
`ifdef POINT_STEP_SCHED_SATURATE_EN
        r = (v < STEP) ? 8'h00 : (v - STEP);
`else
        r = v - STEP;
`endif
      end
      OP_HOLD: r = v;
      OP_CLR:  r = 8'h00;
      default: r = v;
    endcase
    return r;
  endfunction

`ifdef POINT_STEP_SCHED_SATURATE_EN
  function automatic logic step_clip(input logic [7:0] v, input t_point_op op);
    logic c;
    case (op)
      OP_INC:  c = (v > (8'hff - STEP));
      OP_DEC:  c = (v < STEP);
      default: c = 1'b0;
    endcase
    return c;
  endfunction
`endif

  // Result point
  always_comb begin
    o_pnt.x = step_val(i_pnt.x, i_op);
    o_pnt.y = step_val(i_pnt.y, i_op);
`ifdef POINT_STEP_SCHED_SATURATE_EN
    o_sat = step_clip(i_pnt.x, i_op) | step_clip(i_pnt.y, i_op);
`endif
  end

endmodule

// File: rtl/point_step_sched.sv
// Round-robin scheduler sharing one point_step_alu among NREQ requesters.
// POINT_STEP_SCHED_SATURATE_EN adds the registered sat output.
module point_step_sched
  import point_pkg::*;
#(
  parameter int         NREQ = 2,
  parameter logic [7:0] STEP = 8'd1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_vld,
  output logic [NREQ-1:0]           req_rdy,
  input  logic [NREQ*16-1:0]        req_pnt,
  input  logic [NREQ*2-1:0]         req_op,
  output logic                      rsp_vld,
  input  logic                      rsp_rdy,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
`ifdef POINT_STEP_SCHED_SATURATE_EN
  output logic                      sat,
`endif
  output t_point                    rsp_pnt
);

  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

  t_sched_state    r_state, w_state_nxt;
  logic [IDW-1:0]  r_last_gnt, r_op_id, w_gnt;
  logic            w_any;
  logic [NREQ-1:0] w_req_rdy;
  t_point          r_op_pnt, w_alu_pnt;
  t_point_op       r_op;
`ifdef POINT_STEP_SCHED_SATURATE_EN
  logic            w_alu_sat;
`endif

  // First valid index after last, wrapping; descending scan so the nearest wins.
  function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] vld,
                                             input logic [IDW-1:0]  last);
    logic [IDW-1:0] pick;
    int idx;
    pick = last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last) + k) % NREQ;
      if (vld[idx]) pick = IDW'(idx);
    end
    return pick;
  endfunction

  assign w_gnt   = rr_pick(req_vld, r_last_gnt);
  assign w_any   = |req_vld;
  assign req_rdy = rst ? '0 : w_req_rdy;

  point_step_alu #(.STEP(STEP)) u_alu (
    .i_pnt (r_op_pnt),
    .i_op  (r_op),
`ifdef POINT_STEP_SCHED_SATURATE_EN
    .o_sat (w_alu_sat),
`endif
    .o_pnt (w_alu_pnt)
  );

  // Next state and request accept
  always_comb begin
    w_state_nxt = r_state;
    w_req_rdy   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_req_rdy[w_gnt] = 1'b1;
          w_state_nxt      = ST_EXEC;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_vld && rsp_rdy) w_state_nxt = ST_IDLE;
        else                    w_state_nxt = ST_RESP;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Operand capture, response registers and fairness pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld    <= 1'b0;
      rsp_id     <= '0;
      rsp_pnt    <= POINT_ZERO;
      r_last_gnt <= LAST_RST;
      r_op_pnt   <= POINT_ZERO;
      r_op       <= OP_HOLD;
      r_op_id    <= '0;
`ifdef POINT_STEP_SCHED_SATURATE_EN
      sat        <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_op_pnt <= req_pnt[w_gnt*16 +: 16];
            r_op     <= t_point_op'(req_op[w_gnt*2 +: 2]);
            r_op_id  <= w_gnt;
          end
        end
        ST_EXEC: begin
          rsp_pnt <= w_alu_pnt;
          rsp_id  <= r_op_id;
          rsp_vld <= 1'b1;
`ifdef POINT_STEP_SCHED_SATURATE_EN
          sat     <= w_alu_sat;
`endif
        end
        ST_RESP: begin
          // Fairness advances only when a response is actually consumed.
          if (rsp_rdy) begin
            rsp_vld    <= 1'b0;
            r_last_gnt <= rsp_id;
          end
        end
        default: rsp_vld <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_point_step_sched.sv
// Self-checking bench for point_step_sched: directed scenarios plus random traffic
// against a transaction-level model of arbitration and per-field arithmetic.
module tb_point_step_sched;
  import point_pkg::*;

  localparam int         NREQ = 2;
  localparam logic [7:0] STEP = 8'd1;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_vld, req_rdy;
  logic [NREQ*16-1:0]  req_pnt;
  logic [NREQ*2-1:0]   req_op;
  logic                rsp_vld, rsp_rdy;
  logic [$clog2(NREQ)-1:0] rsp_id;
  t_point              rsp_pnt;
`ifdef POINT_STEP_SCHED_SATURATE_EN
  logic                sat;
`endif

  t_point pnt_a [NREQ];
  int     op_a  [NREQ];
  int     checks = 0;
  int     errors = 0;
  int     model_last = NREQ - 1;

  always #5 clk = ~clk;

  point_step_sched #(.NREQ(NREQ), .STEP(STEP)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_vld (req_vld),
    .req_rdy (req_rdy),
    .req_pnt (req_pnt),
    .req_op  (req_op),
    .rsp_vld (rsp_vld),
    .rsp_rdy (rsp_rdy),
    .rsp_id  (rsp_id),
`ifdef POINT_STEP_SCHED_SATURATE_EN
    .sat     (sat),
`endif
    .rsp_pnt (rsp_pnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_pnt[i*16 +: 16] = pnt_a[i];
      req_op[i*2 +: 2]    = 2'(op_a[i]);
    end
  endtask

  // One field of the reference result: {clipped, value}.
  function automatic logic [8:0] mfield(input int v, input int op);
    int r;
    bit c;
    c = 1'b0;
    r = v;
    if (op == 0) begin
      r = v + int'(STEP);
`ifdef POINT_STEP_SCHED_SATURATE_EN
      if (r > 255) begin r = 255; c = 1'b1; end
`else
      r = r % 256;
`endif
    end else if (op == 1) begin
      r = v - int'(STEP);
`ifdef POINT_STEP_SCHED_SATURATE_EN
      if (r < 0) begin r = 0; c = 1'b1; end
`else
      if (r < 0) r = r + 256;
`endif
    end else if (op == 3) begin
      r = 0;
    end
    return {c, 8'(r)};
  endfunction

  function automatic int model_pick(input logic [NREQ-1:0] vld);
    for (int k = 1; k <= NREQ; k++)
      if (vld[(model_last + k) % NREQ]) return (model_last + k) % NREQ;
    return -1;
  endfunction

  function automatic t_point rnd_pnt();
    t_point p;
    logic [7:0] f [2];
    for (int i = 0; i < 2; i++) begin
      case ($urandom_range(0, 4))
        0:       f[i] = 8'h00;
        1:       f[i] = 8'hff;
        2:       f[i] = 8'hfe;
        default: f[i] = 8'($urandom_range(0, 255));
      endcase
    end
    p.x = f[0];
    p.y = f[1];
    return p;
  endfunction

  // Full transaction from IDLE: grant, EXEC, RESP (with optional stall), back to IDLE.
  task automatic run_txn(input logic [NREQ-1:0] vld, input int stall, input string tag);
    int g;
    logic [8:0] fx, fy;
    t_point exp_p;
    req_vld = vld;
    drive();
    #1;
    g = model_pick(vld);
    fx = mfield(int'(pnt_a[g].x), op_a[g]);
    fy = mfield(int'(pnt_a[g].y), op_a[g]);
    exp_p.x = fx[7:0];
    exp_p.y = fy[7:0];
    chk({tag, "_grant"}, 32'(req_rdy), 32'(1 << g));
    @(posedge clk); #1;
    chk({tag, "_exec_vld"}, 32'(rsp_vld), 32'd0);
    chk({tag, "_exec_rdy"}, 32'(req_rdy), 32'd0);
    rsp_rdy = (stall == 0);
    @(posedge clk); #1;
    chk({tag, "_rsp_vld"}, 32'(rsp_vld), 32'd1);
    chk({tag, "_rsp_id"},  32'(rsp_id),  32'(g));
    chk({tag, "_rsp_pnt"}, 32'(rsp_pnt), 32'(exp_p));
    chk({tag, "_resp_rdy"}, 32'(req_rdy), 32'd0);
`ifdef POINT_STEP_SCHED_SATURATE_EN
    chk({tag, "_sat"}, 32'(sat), 32'(fx[8] | fy[8]));
`endif
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_vld"}, 32'(rsp_vld), 32'd1);
      chk({tag, "_hold_id"},  32'(rsp_id),  32'(g));
      chk({tag, "_hold_pnt"}, 32'(rsp_pnt), 32'(exp_p));
      chk({tag, "_hold_rdy"}, 32'(req_rdy), 32'd0);
    end
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    model_last = g;
    chk({tag, "_done_vld"}, 32'(rsp_vld), 32'd0);
  endtask

  initial begin
    int g;
    rst     = 1'b1;
    req_vld = 2'b11;
    rsp_rdy = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      pnt_a[i] = POINT_ZERO;
      op_a[i]  = 2;
    end
    drive();

    // Reset held with requests pending
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("rst_rdy", 32'(req_rdy), 32'd0);
      chk("rst_vld", 32'(rsp_vld), 32'd0);
    end
    chk("rst_id",  32'(rsp_id),  32'd0);
    chk("rst_pnt", 32'(rsp_pnt), 32'd0);
`ifdef POINT_STEP_SCHED_SATURATE_EN
    chk("rst_sat", 32'(sat), 32'd0);
`endif
    rst = 1'b0;

    pnt_a[0] = '{x: 8'h10, y: 8'h20}; op_a[0] = 0;
    pnt_a[1] = '{x: 8'h33, y: 8'h44}; op_a[1] = 2;
    run_txn(2'b11, 0, "inc");

    pnt_a[1] = '{x: 8'hff, y: 8'h00}; op_a[1] = 0;
    run_txn(2'b10, 0, "edge_inc");
    pnt_a[1] = '{x: 8'h00, y: 8'h05}; op_a[1] = 1;
    run_txn(2'b10, 0, "edge_dec");

    pnt_a[0] = '{x: 8'h01, y: 8'h02}; op_a[0] = 0;
    pnt_a[1] = '{x: 8'h80, y: 8'h7f}; op_a[1] = 1;
    for (int i = 0; i < 6; i++) run_txn(2'b11, 0, "fair");

    pnt_a[0] = '{x: 8'h5a, y: 8'ha5}; op_a[0] = 3;
    run_txn(2'b01, 5, "bp");

    // Reset during EXEC discards the operation
    req_vld = 2'b11;
    drive();
    #1;
    g = model_pick(2'b11);
    chk("mid_grant", 32'(req_rdy), 32'(1 << g));
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(req_rdy), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_vld", 32'(rsp_vld), 32'd0);
    rst = 1'b0;
    model_last = NREQ - 1;
    pnt_a[0] = '{x: 8'h7f, y: 8'h80}; op_a[0] = 0;
    run_txn(2'b11, 0, "post_rst");

    // Random traffic
    for (int n = 0; n < 40; n++) begin
      logic [NREQ-1:0] v;
      v = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        pnt_a[i] = rnd_pnt();
        op_a[i]  = $urandom_range(0, 3);
      end
      if (v == '0) begin
        req_vld = '0;
        drive();
        #1;
        chk("rnd_idle_rdy", 32'(req_rdy), 32'd0);
        @(posedge clk); #1;
        chk("rnd_idle_vld", 32'(rsp_vld), 32'd0);
      end else begin
        run_txn(v, $urandom_range(0, 2), "rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
